branch_predictor_bht: RTL and testbench
=======================================

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter ENTRIES, default 64, pattern-history-table depth (power of two, 4..1024).
REQ-003 SHALL have parameter GHR_W, default 6, global history length (GHR_W <= log2(ENTRIES)).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pc_f  input  XLEN  fetch-stage PC.
REQ-007 SHALL have port instr_f  input  32  fetch-stage instruction.
REQ-008 SHALL have port res_valid  input  1  execute-stage resolution valid.
REQ-009 SHALL have ports res_pc / res_target  input  XLEN  resolved instruction PC / actual taken target.
REQ-010 SHALL have ports res_is_cond, res_taken, res_pred_taken  input  1  conditional-branch flag, actual outcome, prediction carried down the pipe.
REQ-011 SHALL have port res_idx  input  log2(ENTRIES)  table index carried down the pipe from pred_idx_f.
REQ-012 SHALL have ports pc_out  output  XLEN  next fetch PC; pred_taken_f  output  1; pred_idx_f  output  log2(ENTRIES).
REQ-013 SHALL have ports flush_fd, flush_de  output  1  pipeline flush; br_count, mispred_count  output  32  performance counters.

Function
REQ-014 SHALL hold ENTRIES 2-bit saturating counters; counter MSB=1 means predict taken.
REQ-015 SHALL index the table with pc_f[log2(ENTRIES)+1:2] (Configuration may XOR in history).
REQ-016 SHALL predict, combinationally in the same cycle: JAL (1101111) -> pc_f + J-imm, pred_taken_f=1; B-type (1100011) -> pc_f + B-imm if counter MSB else pc_f+4; all others incl. JALR -> pc_f+4, pred_taken_f=0.
REQ-017 SHALL sign-extend immediates to XLEN; additions wrap modulo 2^XLEN.
REQ-018 SHALL flag mispredict when res_valid & (res_taken != res_pred_taken) for conditional branches, or res_valid & res_taken for JALR.
REQ-019 SHALL on mispredict assert flush_fd=flush_de=1 in the same cycle and drive pc_out = res_taken ? res_target : res_pc+4, overriding fetch prediction.
REQ-020 SHALL on res_valid & res_is_cond update counter[res_idx] at the next edge: +1 if taken, -1 if not, saturating at 00 and 11.
REQ-021 SHALL, when prediction read and update hit the same index in one cycle, predict from the pre-update value (no bypass).
REQ-022 SHALL increment br_count on every res_valid & res_is_cond and mispred_count on every mispredict; both saturate at 0xFFFF_FFFF.
REQ-023 SHALL keep flush_fd/flush_de low whenever res_valid=0.

Reset
REQ-024 SHALL on rst set every counter to 01 (weakly not-taken) within one cycle, GHR to 0, both performance counters to 0.
REQ-025 SHALL give rst priority over a coincident resolve update (update discarded).
REQ-026 SHALL keep outputs combinational during reset: pc_out=pc_f+4 for non-jump instr_f, flushes follow REQ-019.

Configuration
REQ-027 SHALL compile gshare indexing in with macro BRANCH_PREDICTOR_GSHARE_EN: index = PC bits XOR zero-extended GHR; GHR shifts in res_taken on each res_valid & res_is_cond (not rst).
REQ-028 SHALL without BRANCH_PREDICTOR_GSHARE_EN contain no GHR register and index by PC bits only.

Structure
REQ-029 SHALL place ctr_t (2-bit counter type), opcode constants (OP_JAL, OP_JALR, OP_BRANCH) and immediate-extraction functions in package bp_pkg.
REQ-030 SHALL implement the counter array with reset and saturating update as sub-module bp_counter_table.

Verification
REQ-031 SHALL cover: after rst, B-type at pc_f=0x100 with B-imm=+16 -> pc_out=0x104, pred_taken_f=0.
REQ-032 SHALL cover: two taken resolves on same res_idx -> next fetch of that branch predicts 0x110; five more taken -> counter stays 11.
REQ-033 SHALL cover: res_valid, res_is_cond, res_taken=1, res_pred_taken=0, res_target=0x200 -> flush_fd=flush_de=1, pc_out=0x200, mispred_count+1.
REQ-034 SHALL cover: JALR resolve taken to 0x3A0 -> flush, pc_out=0x3A0; JAL at 0x40 with J-imm=-8 -> pc_out=0x38, no flush.
REQ-035 SHALL cover: rst asserted coincident with a taken resolve -> counter reads 01 afterwards, counters 0.
REQ-036 SHALL cover (GSHARE_EN): alternating T/N pattern on one PC -> after warm-up mispred_count stops incrementing.

Source files
------------

// File: rtl/branch_predictor_bht_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg -- shared types and helpers for the branch_predictor_bht block.
//
// Contents:
//   ctr_t            2-bit saturating direction counter (MSB=1 -> predict taken)
//   CTR_*            named counter values
//   OP_JAL/OP_JALR/OP_BRANCH   RV32 major opcodes the predictor decodes
//   imm_b / imm_j    B-type / J-type immediate extraction, sign-extended to 32b
//   ctr_update       saturating +1 / -1 step of a direction counter
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;  // strongly not-taken
    localparam ctr_t CTR_WNT = 2'b01;  // weakly not-taken (reset value)
    localparam ctr_t CTR_WT  = 2'b10;  // weakly taken
    localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // B-type: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7], bit 0 implied zero.
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type: imm[20|10:1|11|19:12] in [31:12], bit 0 implied zero.
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht_if -- fetch / resolve / redirect bundle of the predictor.
//
// Parameters: XLEN (address width), ENTRIES (pattern-history-table depth).
// Signals:
//   fetch   : pc_f, instr_f                              (to predictor)
//   resolve : res_valid, res_pc, res_target, res_is_cond,
//             res_taken, res_pred_taken, res_idx         (to predictor)
//   result  : pc_out, pred_taken_f, pred_idx_f, flush_fd, flush_de,
//             br_count, mispred_count                    (from predictor)
// Modports: slave = predictor side, master = pipeline side.
// -----------------------------------------------------------------------------
interface branch_predictor_bht_if #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [XLEN-1:0]  pc_f;
    logic [31:0]      instr_f;
    logic             res_valid;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  res_target;
    logic             res_is_cond;
    logic             res_taken;
    logic             res_pred_taken;
    logic [IDX_W-1:0] res_idx;

    logic [XLEN-1:0]  pc_out;
    logic             pred_taken_f;
    logic [IDX_W-1:0] pred_idx_f;
    logic             flush_fd;
    logic             flush_de;
    logic [31:0]      br_count;
    logic [31:0]      mispred_count;

    modport slave (
        input  pc_f, instr_f, res_valid, res_pc, res_target,
               res_is_cond, res_taken, res_pred_taken, res_idx,
        output pc_out, pred_taken_f, pred_idx_f, flush_fd, flush_de,
               br_count, mispred_count
    );

    modport master (
        output pc_f, instr_f, res_valid, res_pc, res_target,
               res_is_cond, res_taken, res_pred_taken, res_idx,
        input  pc_out, pred_taken_f, pred_idx_f, flush_fd, flush_de,
               br_count, mispred_count
    );

endinterface

// File: rtl/branch_predictor_bht_counter_table.sv
// -----------------------------------------------------------------------------
// bp_counter_table -- array of ENTRIES 2-bit saturating direction counters.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (all counters -> 01)
//   rd_idx_i      combinational read index
//   rd_ctr_o      counter value at rd_idx_i (state before any update this cycle)
//   upd_en_i      apply a resolved outcome at the next rising edge
//   upd_idx_i     counter to update
//   upd_taken_i   resolved direction (+1 taken, -1 not taken, saturating)
// -----------------------------------------------------------------------------
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output ctr_t             rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    ctr_t ctr_q [ENTRIES];
    ctr_t upd_ctr_d;

    // Reads see the registered value only, so a same-cycle update never bypasses.
    assign rd_ctr_o  = ctr_q[rd_idx_i];
    assign upd_ctr_d = ctr_update(ctr_q[upd_idx_i], upd_taken_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this is a flop array, not a RAM macro, so every entry can be
            // cleared in one cycle; reset also wins over a coincident update.
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_en_i) begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            ctr_q[upd_idx_i] <= upd_ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht -- bimodal (optionally gshare) branch predictor with
// execute-stage misprediction recovery and performance counters.
//
// Parameters: XLEN (address width), ENTRIES (table depth, power of two 4..1024),
//             GHR_W (global history length, <= log2(ENTRIES)).
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bp    branch_predictor_bht_if.slave: fetch inputs, resolve inputs,
//         next-fetch PC, prediction, flushes and counters
//
// Build option: define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history
// register into the table index; without it no history register exists and
// the table is indexed by PC bits only.
//
// Fetch prediction is purely combinational: JAL always taken to pc+J-imm,
// B-type follows the counter MSB, everything else (including JALR) falls
// through to pc+4. A mispredicted resolve overrides the prediction and raises
// both flushes in the same cycle, including while rst is asserted.
// -----------------------------------------------------------------------------
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int GHR_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_bht_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);

    if (ENTRIES < 4 || ENTRIES > 1024 || (1 << IDX_W) != ENTRIES ||
        GHR_W < 1 || GHR_W > IDX_W) begin : g_param_check
        $error("branch_predictor_bht: ENTRIES must be a power of two in 4..1024 and 1 <= GHR_W <= log2(ENTRIES)");
    end

    logic [6:0]      opcode;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] rd_idx;
    ctr_t            rd_ctr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jal_tgt;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic [XLEN-1:0] res_redirect;
    logic            mispredict;
    logic            upd_en;
    logic [31:0]     br_count_q,      br_count_d;
    logic [31:0]     mispred_count_q, mispred_count_d;

    assign opcode   = bp.instr_f[6:0];
    assign pc_idx   = bp.pc_f[IDX_W+1:2];
    assign upd_en   = bp.res_valid & bp.res_is_cond;

    // Sign-extending size casts; the adds wrap modulo 2^XLEN.
    assign pc_plus4 = bp.pc_f + XLEN'(4);
    assign br_tgt   = bp.pc_f + XLEN'($signed(imm_b(bp.instr_f)));
    assign jal_tgt  = bp.pc_f + XLEN'($signed(imm_j(bp.instr_f)));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Shift the resolved direction in at the LSB; the oldest outcome drops off.
    assign ghr_d  = upd_en ? GHR_W'({ghr_q, bp.res_taken}) : ghr_q;
    assign rd_idx = pc_idx ^ IDX_W'(ghr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign rd_idx = pc_idx;
`endif

    bp_counter_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_counter_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (rd_idx),
        .rd_ctr_o    (rd_ctr),
        .upd_en_i    (upd_en),
        .upd_idx_i   (bp.res_idx),
        .upd_taken_i (bp.res_taken)
    );

    // Fetch-stage prediction.
    always_comb begin
        // NOTE: combinational blocks use blocking assignment and give every
        // output a default first, so no path can leave a latch behind.
        pred_pc    = pc_plus4;
        pred_taken = 1'b0;
        case (opcode)
            OP_JAL: begin
                pred_pc    = jal_tgt;
                pred_taken = 1'b1;
            end
            OP_BRANCH: begin
                if (rd_ctr >= CTR_WT) begin
                    pred_pc    = br_tgt;
                    pred_taken = 1'b1;
                end
            end
            OP_JALR: begin
                // Register-indirect target is unknown at fetch: fall through.
                pred_pc    = pc_plus4;
                pred_taken = 1'b0;
            end
            default: ;
        endcase
    end

    // Resolve-stage recovery. A non-conditional resolve is wrong only when it
    // was taken but fetch did not redirect (JALR); a JAL arrives with
    // res_pred_taken=1 and needs no recovery.
    always_comb begin
        mispredict   = 1'b0;
        res_redirect = bp.res_taken ? bp.res_target : bp.res_pc + XLEN'(4);
        if (bp.res_valid) begin
            if (bp.res_is_cond) begin
                mispredict = bp.res_taken ^ bp.res_pred_taken;
            end else begin
                mispredict = bp.res_taken & ~bp.res_pred_taken;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_en && br_count_q != 32'hFFFF_FFFF) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict && mispred_count_q != 32'hFFFF_FFFF) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign bp.pc_out        = mispredict ? res_redirect : pred_pc;
    assign bp.pred_taken_f  = pred_taken;
    assign bp.pred_idx_f    = rd_idx;
    assign bp.flush_fd      = mispredict;
    assign bp.flush_de      = mispredict;
    assign bp.br_count      = br_count_q;
    assign bp.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht -- self-checking bench for branch_predictor_bht.
// A behavioural model (integer counter array, integer history, plain
// arithmetic on instruction offsets) predicts every combinational output and
// the performance counters; constant tables and hand sequences pin down the
// corner cases. Honours BRANCH_PREDICTOR_GSHARE_EN like the design.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int GHR_W   = 6;
    localparam int IDX_W   = 6;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    typedef enum int {K_OTHER, K_JAL, K_JALR, K_BR} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] pc;
        int          off;
        bit          rv, cond, tk, ptk;
        logic [31:0] rpc, rtgt;
        int          ridx;
        logic [31:0] exp_pc;
        bit          exp_pt;
        bit          exp_flush;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_bht_if #(.XLEN(XLEN), .ENTRIES(ENTRIES)) bp_if ();

    branch_predictor_bht #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .GHR_W   (GHR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int     m_ctr [ENTRIES];
    int     m_ghr = 0;
    longint m_br  = 0;
    longint m_mis = 0;

    // Outputs sampled in the most recent cycle.
    logic [31:0]      obs_pc;
    logic             obs_pt, obs_fd, obs_de;
    logic [IDX_W-1:0] obs_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ghr_next(input int g, input bit taken);
        return GSHARE ? (((g << 1) | int'(taken)) & ((1 << GHR_W) - 1)) : 0;
    endfunction

    function automatic int m_index(input logic [31:0] pc, input int g);
        return (int'(pc >> 2) ^ (GSHARE ? g : 0)) & (ENTRIES - 1);
    endfunction

    // A fetch PC whose table index is idx under history g.
    function automatic logic [31:0] pc_for(input int idx, input int g);
        return 32'(((idx ^ (GSHARE ? g : 0)) & (ENTRIES - 1)) << 2);
    endfunction

    // Build an instruction of the given kind carrying byte offset off.
    function automatic logic [31:0] enc(input kind_e k, input int off);
        logic [20:0] o;
        o = 21'(off);
        case (k)
            K_JAL:   return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
            K_BR:    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
            K_JALR:  return {12'h000, 5'd1, 3'b000, 5'd0, 7'b1100111};
            default: return 32'h0000_0013;
        endcase
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input kind_e k, input logic [31:0] pc, input int off,
                         input bit rv, input bit cond, input bit tk, input bit ptk,
                         input logic [31:0] rpc, input logic [31:0] rtgt,
                         input int ridx, input bit r);
        int          idx, ri;
        logic [31:0] exp_pred, exp_pc;
        bit          exp_pt, mis;
        ri                    = ridx & (ENTRIES - 1);
        rst                   = r;
        bp_if.pc_f            = pc;
        bp_if.instr_f         = enc(k, off);
        bp_if.res_valid       = rv;
        bp_if.res_is_cond     = cond;
        bp_if.res_taken       = tk;
        bp_if.res_pred_taken  = ptk;
        bp_if.res_pc          = rpc;
        bp_if.res_target      = rtgt;
        bp_if.res_idx         = IDX_W'(ri);
        #4;
        obs_pc  = bp_if.pc_out;
        obs_pt  = bp_if.pred_taken_f;
        obs_idx = bp_if.pred_idx_f;
        obs_fd  = bp_if.flush_fd;
        obs_de  = bp_if.flush_de;

        idx      = m_index(pc, m_ghr);
        exp_pt   = 1'b0;
        exp_pred = pc + 32'd4;
        if (k == K_JAL || (k == K_BR && m_ctr[idx] >= 2)) begin
            exp_pt   = 1'b1;
            exp_pred = pc + 32'(off);
        end
        mis    = rv && (cond ? (tk != ptk) : (tk && !ptk));
        exp_pc = mis ? (tk ? rtgt : rpc + 32'd4) : exp_pred;

        check("model pc_out",       obs_pc,  exp_pc);
        check("model pred_taken_f", 32'(obs_pt),  32'(exp_pt));
        check("model pred_idx_f",   32'(obs_idx), 32'(idx));
        check("model flush_fd",     32'(obs_fd),  32'(mis));
        check("model flush_de",     32'(obs_de),  32'(mis));

        @(posedge clk);
        if (r) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_ghr = 0;
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (rv && cond) begin
                m_ctr[ri] = tk ? ((m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1)
                               : ((m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1);
                if (m_br < 64'hFFFF_FFFF) m_br++;
                m_ghr = ghr_next(m_ghr, tk);
            end
            if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
        #1;
        check("model br_count",      bp_if.br_count,      32'(m_br));
        check("model mispred_count", bp_if.mispred_count, 32'(m_mis));
        @(negedge clk);
    endtask

    task automatic fetch(input kind_e k, input logic [31:0] pc, input int off);
        cycle(k, pc, off, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    endtask

    task automatic resolve(input bit tk, input bit ptk, input int ridx);
        cycle(K_OTHER, 32'h0, 0, 1'b1, 1'b1, tk, ptk, 32'h0, 32'h0, ridx, 1'b0);
    endtask

    task automatic do_reset();
        cycle(K_OTHER, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    endtask

    vec_t        vecs [10];
    int          g, t, s;
    logic [31:0] pc2;

    initial begin
        foreach (m_ctr[i]) m_ctr[i] = 0;

        // ---------------- reset state and constant vectors ----------------
        do_reset();
        check("reset br_count",      bp_if.br_count,      32'h0);
        check("reset mispred_count", bp_if.mispred_count, 32'h0);

        vecs[0] = '{K_BR,    32'h100,       16,    0,0,0,0, 32'h0,   32'h0,    0, 32'h104,       0, 0};
        vecs[1] = '{K_JAL,   32'h40,        -8,    0,0,0,0, 32'h0,   32'h0,    0, 32'h38,        1, 0};
        vecs[2] = '{K_JALR,  32'h80,        0,     0,0,0,0, 32'h0,   32'h0,    0, 32'h84,        0, 0};
        vecs[3] = '{K_OTHER, 32'h200,       0,     1,0,1,0, 32'h390, 32'h3A0,  0, 32'h3A0,       0, 1};
        vecs[4] = '{K_JAL,   32'h1000,      2048,  1,0,1,1, 32'h4000,32'h5000, 0, 32'h1800,      1, 0};
        vecs[5] = '{K_OTHER, 32'hFFFF_FFFC, 0,     0,0,0,0, 32'h0,   32'h0,    0, 32'h0,         0, 0};
        vecs[6] = '{K_JAL,   32'h4,         -8,    0,0,0,0, 32'h0,   32'h0,    0, 32'hFFFF_FFFC, 1, 0};
        vecs[7] = '{K_BR,    32'h300,       -256,  1,1,0,1, 32'h700, 32'h0,    5, 32'h704,       0, 1};
        vecs[8] = '{K_OTHER, 32'h10,        0,     1,1,1,1, 32'h0,   32'h0,    7, 32'h14,        0, 0};
        vecs[9] = '{K_OTHER, 32'h20,        0,     0,1,1,0, 32'h900, 32'h0,    7, 32'h24,        0, 0};

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].kind, vecs[i].pc, vecs[i].off, vecs[i].rv, vecs[i].cond,
                  vecs[i].tk, vecs[i].ptk, vecs[i].rpc, vecs[i].rtgt, vecs[i].ridx, 1'b0);
            check($sformatf("vec%0d pc_out", i),       obs_pc,      vecs[i].exp_pc);
            check($sformatf("vec%0d pred_taken_f", i), 32'(obs_pt), 32'(vecs[i].exp_pt));
            check($sformatf("vec%0d flush_fd", i),     32'(obs_fd), 32'(vecs[i].exp_flush));
            check($sformatf("vec%0d flush_de", i),     32'(obs_de), 32'(vecs[i].exp_flush));
        end

        // ---------------- conditional mispredict to 0x200 ----------------
        do_reset();
        cycle(K_OTHER, 32'h50, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1F0, 32'h200, 3, 1'b0);
        check("cond mispred pc_out",   obs_pc,      32'h200);
        check("cond mispred flush_fd", 32'(obs_fd), 32'h1);
        check("cond mispred flush_de", 32'(obs_de), 32'h1);
        check("cond mispred count",    bp_if.mispred_count, 32'h1);
        check("cond mispred br_count", bp_if.br_count,      32'h1);

        // ---------------- same-index read and update: no bypass ----------------
        do_reset();
        cycle(K_BR, 32'h100, 16, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, m_index(32'h100, m_ghr), 1'b0);
        check("no-bypass pc_out",     obs_pc,      32'h104);
        check("no-bypass pred_taken", 32'(obs_pt), 32'h0);

        // ---------------- training and saturation ----------------
        do_reset();
        g = ghr_next(ghr_next(m_ghr, 1'b1), 1'b1);
        t = m_index(32'h100, g);
        repeat (2) resolve(1'b1, 1'b1, t);
        fetch(K_BR, 32'h100, 16);
        check("trained pc_out",     obs_pc,      32'h110);
        check("trained pred_taken", 32'(obs_pt), 32'h1);
        g = m_ghr;
        repeat (5) g = ghr_next(g, 1'b1);
        s = m_index(32'h100, g);
        repeat (5) resolve(1'b1, 1'b1, s);
        resolve(1'b0, 1'b1, s);
        pc2 = pc_for(s, m_ghr);
        fetch(K_BR, pc2, 16);
        check("saturated -1 pc_out",     obs_pc,      pc2 + 32'd16);
        check("saturated -1 pred_taken", 32'(obs_pt), 32'h1);
        resolve(1'b0, 1'b1, s);
        pc2 = pc_for(s, m_ghr);
        fetch(K_BR, pc2, 16);
        check("saturated -2 pc_out",     obs_pc,      pc2 + 32'd4);
        check("saturated -2 pred_taken", 32'(obs_pt), 32'h0);

        // ---------------- reset beats a coincident update ----------------
        do_reset();
        resolve(1'b1, 1'b0, m_index(32'h100, m_ghr));
        cycle(K_OTHER, 32'h0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0,
              m_index(32'h100, m_ghr), 1'b1);
        check("rst+update br_count",      bp_if.br_count,      32'h0);
        check("rst+update mispred_count", bp_if.mispred_count, 32'h0);
        fetch(K_BR, 32'h100, 16);
        check("rst+update pred_taken", 32'(obs_pt), 32'h0);
        check("rst+update pc_out",     obs_pc,      32'h104);
        resolve(1'b1, 1'b1, m_index(32'h100, ghr_next(m_ghr, 1'b1)));
        fetch(K_BR, 32'h100, 16);
        check("rst weak-nt +1 pc_out", obs_pc, 32'h110);

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 400; n++) begin
            kind_e       k;
            logic [31:0] pc, rpc, rtgt;
            int          off, ridx;
            bit          rv, cond, tk, ptk, r;
            k    = kind_e'($urandom_range(0, 3));
            pc   = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            off  = (k == K_JAL) ? int'($urandom_range(0, 1048575)) * 2 - 1048576
                                : int'($urandom_range(0, 4095)) * 2 - 4096;
            rv   = 1'($urandom_range(0, 1));
            cond = 1'($urandom_range(0, 1));
            tk   = cond ? 1'($urandom_range(0, 1)) : 1'b1;
            ptk  = 1'($urandom_range(0, 1));
            rpc  = $urandom & 32'hFFFF_FFFC;
            rtgt = $urandom & 32'hFFFF_FFFC;
            ridx = GSHARE ? int'($urandom_range(0, ENTRIES - 1)) : int'($urandom_range(0, 7));
            r    = ($urandom_range(0, 49) == 0);
            cycle(k, pc, off, rv, cond, tk, ptk, rpc, rtgt, ridx, r);
        end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        // ---------------- alternating pattern learned through history ----------------
        begin
            longint mis_snap;
            logic [IDX_W-1:0] p_idx;
            bit p_pt;
            mis_snap = 0;
            do_reset();
            for (int n = 0; n < 40; n++) begin
                fetch(K_BR, 32'h600, 64);
                p_idx = obs_idx;
                p_pt  = obs_pt;
                cycle(K_OTHER, 32'h0, 0, 1'b1, 1'b1, (n % 2) == 0, p_pt,
                      32'h600, 32'h640, int'(p_idx), 1'b0);
                if (n == 19) mis_snap = m_mis;
            end
            check("gshare alternating mispred settles", bp_if.mispred_count, 32'(mis_snap));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
